fifo_pixel_reader: RTL and testbench

Read-side controller for the RGB pixel FIFO in the VGG16 input path. Pops one three-channel pixel word (3×DATA_WIDTH) at a time, honouring the FIFO's gated read-data timing, and serialises it into three single-channel beats on a valid/ready stream feeding the first convolution layer. Optionally tracks the pixel count per frame and flags frame completion.

---
 rtl/fifo_pixel_reader.sv | 82 ++++++++
 tb/tb_fifo_pixel_reader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pixel_reader.sv
// fifo_pixel_reader: pops RGB pixel words from a FIFO and serialises them into three channel beats; define PIXEL_CNT_EN for per-frame pixel counting
module fifo_pixel_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_PIXELS = 50176,
  parameter int CNT_WIDTH = $clog2(FRAME_PIXELS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  input  logic [3*DATA_WIDTH-1:0] fifo_data,
  output logic                    fifo_rd_req,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic [1:0]              m_chan,
  output logic                    m_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [CNT_WIDTH-1:0]    pixel_count,
  output logic                    frame_done
);
  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;
  state_t state;
  logic empty_q;
  logic [2*DATA_WIDTH-1:0] hold;
  // Pixel FSM: m_chan doubles as the beat counter; channel 0 goes straight to m_data, channels 1-2 wait in hold
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      empty_q <= 1'b1;
      fifo_rd_req <= 1'b0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_chan <= 2'd0;
      m_last <= 1'b0;
      hold <= '0;
    end else begin
      empty_q <= fifo_empty;
      case (state)
        IDLE: if (!fifo_empty && !empty_q) begin
          state <= FETCH;
          fifo_rd_req <= 1'b1;
        end
        FETCH: begin
          state <= SEND;
          fifo_rd_req <= 1'b0;
          hold <= fifo_data[3*DATA_WIDTH-1:DATA_WIDTH];
          m_data <= fifo_data[DATA_WIDTH-1:0];
          m_chan <= 2'd0;
          m_last <= 1'b0;
          m_valid <= 1'b1;
        end
        SEND: if (m_ready) begin
          m_data <= m_chan == 2'd0 ? hold[DATA_WIDTH-1:0] : hold[2*DATA_WIDTH-1:DATA_WIDTH];
          m_chan <= m_last ? 2'd0 : m_chan + 2'd1;
          m_last <= m_chan == 2'd1;
          if (m_last) begin
            state <= IDLE;
            m_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef PIXEL_CNT_EN
  // Frame counter: counts accepted last beats, wraps at FRAME_PIXELS and pulses frame_done on the wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_count <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == SEND && m_ready && m_last) begin
        pixel_count <= pixel_count == CNT_WIDTH'(FRAME_PIXELS - 1) ? '0 : pixel_count + CNT_WIDTH'(1);
        frame_done <= pixel_count == CNT_WIDTH'(FRAME_PIXELS - 1);
      end
    end
  end
`else
  assign pixel_count = '0;
  assign frame_done = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_pixel_reader.sv
// tb_fifo_pixel_reader: directed table-driven bench with a small FIFO model and a handshake monitor
module tb_fifo_pixel_reader;
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  chan;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fifo_empty = 1'b1;
  logic [95:0] fifo_data = '0;
  logic fifo_rd_req;
  logic [31:0] m_data;
  logic [1:0] m_chan;
  logic m_last, m_valid;
  logic m_ready = 1'b0;
  logic [1:0] pixel_count;
  logic frame_done;

  fifo_pixel_reader #(.DATA_WIDTH(32), .FRAME_PIXELS(4)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_req(fifo_rd_req), .m_data(m_data), .m_chan(m_chan), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready), .pixel_count(pixel_count), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int last_rd = -100;
  int fd_cnt = 0;
  int pc_max = 0;
  logic [95:0] q[$];
  logic [95:0] pending[$];
  beat_t rcv[$];
  logic [95:0] pix_t[4];
  beat_t exp_t[12];
  logic pv = 1'b0, pr = 1'b0, prst = 1'b1;
  beat_t pb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model: pending pushes land on the edge, pops follow the registered read strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) q.delete();
    else if (fifo_rd_req && q.size() > 0) void'(q.pop_front());
    while (pending.size() > 0) q.push_back(pending.pop_front());
    fifo_empty <= q.size() == 0;
    fifo_data <= q.size() > 0 ? q[0] : 96'd0;
  end

  // Monitor a little after the falling edge so inputs set on that edge are settled
  always @(negedge clk) begin
    #1;
    if (fifo_rd_req) begin
      chk("rd_spacing", 64'(cyc - last_rd >= 4), 64'd1);
      last_rd = cyc;
      rd_cnt++;
    end
    if (pv && !pr && !prst)
      chk("stable", {m_valid, m_data, m_chan, m_last}, {1'b1, pb});
    if (m_valid && m_ready && !rst) rcv.push_back({m_data, m_chan, m_last});
    if (frame_done) fd_cnt++;
    if (int'(pixel_count) > pc_max) pc_max = int'(pixel_count);
    pv = m_valid;
    pr = m_ready;
    prst = rst;
    pb = {m_data, m_chan, m_last};
  end

  task automatic wait_beats(input int want, input int lim);
    int n = 0;
    while (rcv.size() < want && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("beat_count", 64'(rcv.size()), 64'(want));
  endtask

  task automatic wait_valid(input int lim);
    int n = 0;
    while (!m_valid && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("valid_seen", 64'(m_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, rd0;
    pix_t[0] = {32'h3, 32'h2, 32'h1};
    pix_t[1] = {32'hCC, 32'hBB, 32'hAA};
    pix_t[2] = {32'h8000_0000, 32'h0, 32'hFFFF_FFFF};
    pix_t[3] = {32'h1234_5678, 32'hDEAD_BEEF, 32'h0F0F_0F0F};
    exp_t[0]  = {32'h1, 2'd0, 1'b0};
    exp_t[1]  = {32'h2, 2'd1, 1'b0};
    exp_t[2]  = {32'h3, 2'd2, 1'b1};
    exp_t[3]  = {32'hAA, 2'd0, 1'b0};
    exp_t[4]  = {32'hBB, 2'd1, 1'b0};
    exp_t[5]  = {32'hCC, 2'd2, 1'b1};
    exp_t[6]  = {32'hFFFF_FFFF, 2'd0, 1'b0};
    exp_t[7]  = {32'h0, 2'd1, 1'b0};
    exp_t[8]  = {32'h8000_0000, 2'd2, 1'b1};
    exp_t[9]  = {32'h0F0F_0F0F, 2'd0, 1'b0};
    exp_t[10] = {32'hDEAD_BEEF, 2'd1, 1'b0};
    exp_t[11] = {32'h1234_5678, 2'd2, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_rd_req", 64'(fifo_rd_req), 64'd0);
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
    chk("rst_chan", 64'(m_chan), 64'd0);
    chk("rst_last", 64'(m_last), 64'd0);
    chk("rst_count", 64'(pixel_count), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    rst = 1'b0;
    rd_cnt = 0;
    repeat (2) @(negedge clk);
    chk("idle_rd", 64'(rd_cnt), 64'd0);
    chk("idle_valid", 64'(m_valid), 64'd0);

    m_ready = 1'b1;
    rcv.delete();
    pending.push_back(pix_t[0]);
    @(negedge clk);
    t0 = cyc;
    chk("empty_fell", 64'(fifo_empty), 64'd0);
    wait_valid(20);
    chk("latency", 64'(cyc - t0), 64'd3);
    wait_beats(3, 20);
    for (int i = 0; i < 3; i++) chk("single_beat", 64'(rcv[i]), 64'(exp_t[i]));
    repeat (3) @(negedge clk);
    chk("single_rd_cnt", 64'(rd_cnt), 64'd1);

    m_ready = 1'b0;
    rcv.delete();
    pending.push_back(pix_t[0]);
    wait_valid(20);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    rd0 = rd_cnt;
    pending.push_back(pix_t[1]);
    repeat (5) begin
      @(negedge clk);
      chk("stall_data", 64'(m_data), 64'd2);
      chk("stall_chan", 64'(m_chan), 64'd1);
    end
    chk("stall_rd", 64'(rd_cnt - rd0), 64'd0);
    m_ready = 1'b1;
    wait_beats(6, 40);
    for (int i = 0; i < 6; i++) chk("bp_beat", 64'(rcv[i]), 64'(exp_t[i]));

    repeat (3) @(negedge clk);
    rcv.delete();
    rd0 = rd_cnt;
    for (int i = 0; i < 4; i++) pending.push_back(pix_t[i]);
    wait_beats(12, 100);
    for (int i = 0; i < 12; i++) chk("burst_beat", 64'(rcv[i]), 64'(exp_t[i]));
    chk("burst_rd_cnt", 64'(rd_cnt - rd0), 64'd4);

    m_ready = 1'b0;
    pending.push_back(pix_t[0]);
    wait_valid(20);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("mid_chan", 64'(m_chan), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", 64'(m_valid), 64'd0);
    chk("rst_mid_chan", 64'(m_chan), 64'd0);
    chk("rst_mid_rd", 64'(fifo_rd_req), 64'd0);
    rst = 1'b0;
    rcv.delete();
    m_ready = 1'b1;
    pending.push_back(pix_t[1]);
    wait_beats(3, 20);
    for (int i = 0; i < 3; i++) chk("after_rst_beat", 64'(rcv[i]), 64'(exp_t[i + 3]));

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fd_cnt = 0;
    pc_max = 0;
    rcv.delete();
    for (int i = 0; i < 4; i++) pending.push_back(pix_t[i]);
    wait_beats(12, 100);
    repeat (3) @(negedge clk);
`ifdef PIXEL_CNT_EN
    chk("frame_done_cycles", 64'(fd_cnt), 64'd1);
    chk("count_peak", 64'(pc_max), 64'd3);
`else
    chk("frame_done_cycles", 64'(fd_cnt), 64'd0);
    chk("count_peak", 64'(pc_max), 64'd0);
`endif
    chk("count_final", 64'(pixel_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
